regfile_wport_arbiter: RTL and testbench
========================================

# regfile_wport_arbiter

- Shares the eight write ports of the 32×64 register file among `NUM_REQ` independent requesters.
- Each cycle it grants up to `NUM_PORTS` requests in round-robin order and never places two writes to the same address on the ports in one cycle.
- Granted writes drive the file's `W*_en/addr/data/mask` signals from one output register stage.
- It sits between the ALU writeback lanes and the register file; read ports are not touched.

## Interface
- `NUM_REQ`, 12, number of write requesters (≥ `NUM_PORTS`)
- `NUM_PORTS`, 8, register-file write ports driven
- `ADDR_W`, 5, register address width
- `DATA_W`, 64, write data width
- `MASK_W`, 8, byte-mask width (`DATA_W/8`)
- `clock`  in  1  the block's only clock; all state is on its rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `hold`  in  1  when high, no grants this cycle (`req_ready` all 0)
- `req_valid`  in  `NUM_REQ`  request present, per requester
- `req_ready`  out  `NUM_REQ`  grant, combinational, same cycle
- `req_addr`  in  `NUM_REQ*ADDR_W`  target register
- `req_data`  in  `NUM_REQ*DATA_W`  write data
- `req_mask`  in  `NUM_REQ*MASK_W`  byte enables
- `w_en`  out  `NUM_PORTS`  registered port enable, maps to `Wk_en`
- `w_addr`  out  `NUM_PORTS*ADDR_W`  registered, maps to `Wk_addr`
- `w_data`  out  `NUM_PORTS*DATA_W`  registered, maps to `Wk_data`
- `w_mask`  out  `NUM_PORTS*MASK_W`  registered, maps to `Wk_mask`
- `rr_ptr_o`  out  `$clog2(NUM_REQ)`  current round-robin start index (debug)

## Operation
- Handshake: a transfer occurs when `req_valid[i] & req_ready[i]`.
  - `req_ready[i]` may depend on every `req_valid` and `req_addr`.
  - A requester must hold `addr/data/mask` stable while `valid` is high and not ready.
- Scan order: `rr_ptr`, `rr_ptr+1`, … wrapping mod `NUM_REQ`. Requester i is granted iff all of the following hold:
  - `valid`;
  - `hold` is 0;
  - fewer than `NUM_PORTS` grants so far this cycle;
  - its address differs from every address already granted this cycle.
- A request skipped for an address conflict or port exhaustion waits; it is not dropped.
- Port assignment: the k-th grant in scan order goes to port k. Unused ports get `w_en=0`, and their addr/data/mask are driven to 0.
- Pointer update:
  - After at least one grant, `rr_ptr` ← (index of last grant + 1) mod `NUM_REQ`.
  - With no grants, `rr_ptr` is unchanged.
- Starvation bound: a continuously valid requester is granted within `NUM_REQ` cycles in which any grant occurs.
- A mask of all zeros is still granted and occupies a port. The arbiter does not filter it.

## Timing
- Latency: a request accepted in cycle t appears on `w_*` in cycle t+1. The register file commits it at the edge ending t+1.
- Throughput: up to `NUM_PORTS` writes per cycle, with no bubbles.
- Reset values: `w_en=0`, `w_addr/w_data/w_mask=0`, `rr_ptr=0`, `req_ready=0` while `reset_n=0`.
- Reset mid-operation:
  - `reset_n` low clears the output register immediately (asynchronously).
  - A write accepted in the cycle before reset is lost. Requesters treat reset as abort.
- `hold` rising: it takes effect in the same cycle. Writes already registered still issue next cycle.
- Same-address requests in the same cycle: only the first in scan order is granted. The other is granted in a later cycle, so at most one write per address reaches the ports per cycle.

## Configuration
- `REGFILE_WPORT_ARB_STATS_EN` defined: adds outputs `stat_grants` (32 bits, total grants) and `stat_conflicts` (32 bits, cycles in which at least one valid request was denied for address conflict).
  - Both counters saturate at `32'hFFFF_FFFF` and reset to 0.
- `REGFILE_WPORT_ARB_STATS_EN` undefined: these ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `regfile_arb_pkg` holds:
  - default widths (`ADDR_W`, `DATA_W`, `MASK_W`);
  - a `wreq_t` struct (addr, data, mask);
  - a `wport_t` struct (en, addr, data, mask).
- One sub-module, `rr_multi_grant`: a combinational scan from `rr_ptr` that produces the grant vector, the port index per grant and the next pointer.
  - The top level holds `rr_ptr`, the output register and the optional counters.

## Test plan
- Reset, then `req_valid=0` → `w_en=0`, `rr_ptr_o=0`, `req_ready=0`.
- 12 requesters valid with distinct addresses 0–11, `rr_ptr=0` → cycle 0 grants 0–7 on ports 0–7, `rr_ptr`→8. Cycle 1 grants 8–11 on ports 0–3. Each write appears on `w_*` one cycle after its grant.
- Requesters 2 and 5 both target address 7, with `rr_ptr=0` → only 2 is granted, 5 is granted next cycle. No cycle shows two `w_en` ports with `w_addr=7`.
- `hold=1` for 3 cycles with all valid → `req_ready=0`, `w_en=0` from the cycle after `hold` rises, `rr_ptr` unchanged.
- Pointer wrap: `rr_ptr=10`, requesters 10, 11, 0 and 1 valid → ports 0–3 = requesters 10, 11, 0, 1, `rr_ptr`→2.
- `reset_n` pulsed low in the cycle after a grant → `w_en` clears asynchronously and the write never reaches the ports.
  - With `REGFILE_WPORT_ARB_STATS_EN`, the counters read 0 after reset, and 1 conflict cycle is counted in the same-address scenario.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared widths and request/port records for the register-file write-port arbiter.
package regfile_arb_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 64;
   localparam int MASK_W = DATA_W / 8;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [MASK_W-1:0] mask;
   } wreq_t;

   typedef struct packed {
      logic              en;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [MASK_W-1:0] mask;
   } wport_t;

endpackage

// File: rtl/rr_multi_grant.sv
// Combinational round-robin scan granting up to NUM_PORTS requests with unique addresses.
// Zero latency; hold or port exhaustion simply leaves requests ungranted.
module rr_multi_grant #(
   parameter int NUM_REQ   = 12,
   parameter int NUM_PORTS = 8,
   parameter int ADDR_W    = 5,
   parameter int PTR_W     = $clog2(NUM_REQ)
) (
   input  logic [PTR_W-1:0]           rr_ptr,
   input  logic                       hold,
   input  logic [NUM_REQ-1:0]         valid,
   input  logic [NUM_REQ*ADDR_W-1:0]  addr,
   output logic [NUM_REQ-1:0]         grant,
   output logic [NUM_PORTS-1:0]       port_vld,
   output logic [NUM_PORTS*PTR_W-1:0] port_src,
   output logic [PTR_W-1:0]           next_ptr,
   output logic                       conflict
);

   logic [(2**ADDR_W)-1:0] used;
   logic [ADDR_W-1:0]      cur_addr;
   int                     idx;
   int                     cnt;

   always_comb begin
      grant    = '0;
      port_vld = '0;
      port_src = '0;
      next_ptr = rr_ptr;
      conflict = 1'b0;
      used     = '0;
      cur_addr = '0;
      idx      = 0;
      cnt      = 0;
      for (int j = 0; j < NUM_REQ; j++) begin
         idx = int'(rr_ptr) + j;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         cur_addr = addr[idx*ADDR_W +: ADDR_W];
         if (valid[idx] && !hold) begin
            // An address clash is flagged even once the ports are full.
            if (used[cur_addr]) begin
               conflict = 1'b1;
            end else if (cnt < NUM_PORTS) begin
               grant[idx]                    = 1'b1;
               port_vld[cnt]                 = 1'b1;
               port_src[cnt*PTR_W +: PTR_W]  = PTR_W'(idx);
               used[cur_addr]                = 1'b1;
               next_ptr = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
               cnt      = cnt + 1;
            end
         end
      end
   end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Shares the register-file write ports among NUM_REQ requesters; one registered stage to w_*.
// Grants are same-cycle via req_ready; hold or contention defers requests. Optional REGFILE_WPORT_ARB_STATS_EN.
module regfile_wport_arbiter #(
   parameter int NUM_REQ   = 12,
   parameter int NUM_PORTS = 8,
   parameter int ADDR_W    = regfile_arb_pkg::ADDR_W,
   parameter int DATA_W    = regfile_arb_pkg::DATA_W,
   parameter int MASK_W    = regfile_arb_pkg::MASK_W,
   parameter int PTR_W     = $clog2(NUM_REQ)
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        hold,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic [NUM_REQ*MASK_W-1:0]   req_mask,
   output logic [NUM_PORTS-1:0]        w_en,
   output logic [NUM_PORTS*ADDR_W-1:0] w_addr,
   output logic [NUM_PORTS*DATA_W-1:0] w_data,
   output logic [NUM_PORTS*MASK_W-1:0] w_mask,
`ifdef REGFILE_WPORT_ARB_STATS_EN
   output logic [31:0]                 stat_grants,
   output logic [31:0]                 stat_conflicts,
`endif
   output logic [PTR_W-1:0]            rr_ptr_o
);
   import regfile_arb_pkg::*;

   // Record field widths come from the package, so the width parameters must keep their defaults.
   wreq_t                 req [NUM_REQ];
   wport_t                port_nxt [NUM_PORTS];
   wport_t                port_q [NUM_PORTS];
   logic [PTR_W-1:0]      rr_ptr;
   logic [PTR_W-1:0]      next_ptr;
   logic [NUM_REQ-1:0]    grant;
   logic [NUM_PORTS-1:0]  port_vld;
   logic [NUM_PORTS*PTR_W-1:0] port_src;
   logic                  conflict;
   int                    src;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      assign req[i].addr = req_addr[i*ADDR_W +: ADDR_W];
      assign req[i].data = req_data[i*DATA_W +: DATA_W];
      assign req[i].mask = req_mask[i*MASK_W +: MASK_W];
   end

   rr_multi_grant #(
      .NUM_REQ   (NUM_REQ),
      .NUM_PORTS (NUM_PORTS),
      .ADDR_W    (ADDR_W),
      .PTR_W     (PTR_W)
   ) u_scan (
      .rr_ptr   (rr_ptr),
      .hold     (hold),
      .valid    (req_valid),
      .addr     (req_addr),
      .grant    (grant),
      .port_vld (port_vld),
      .port_src (port_src),
      .next_ptr (next_ptr),
      .conflict (conflict)
   );

   // No handshake may complete while the block is held in reset.
   assign req_ready = grant & {NUM_REQ{reset_n}};
   assign rr_ptr_o  = rr_ptr;

   always_comb begin
      src = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         port_nxt[k] = '0;
         if (port_vld[k]) begin
            src              = int'(port_src[k*PTR_W +: PTR_W]);
            port_nxt[k].en   = 1'b1;
            port_nxt[k].addr = req[src].addr;
            port_nxt[k].data = req[src].data;
            port_nxt[k].mask = req[src].mask;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr <= '0;
         for (int k = 0; k < NUM_PORTS; k++) port_q[k] <= '0;
      end else begin
         rr_ptr <= next_ptr;
         for (int k = 0; k < NUM_PORTS; k++) port_q[k] <= port_nxt[k];
      end
   end

   for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
      assign w_en[k]                      = port_q[k].en;
      assign w_addr[k*ADDR_W +: ADDR_W]   = port_q[k].addr;
      assign w_data[k*DATA_W +: DATA_W]   = port_q[k].data;
      assign w_mask[k*MASK_W +: MASK_W]   = port_q[k].mask;
   end

`ifdef REGFILE_WPORT_ARB_STATS_EN
   logic [32:0] grant_sum;

   assign grant_sum = {1'b0, stat_grants} + 33'($countones(grant));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stat_grants    <= '0;
         stat_conflicts <= '0;
      end else begin
         stat_grants <= grant_sum[32] ? 32'hFFFF_FFFF : grant_sum[31:0];
         if (conflict && stat_conflicts != 32'hFFFF_FFFF)
            stat_conflicts <= stat_conflicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter with a queue-based scoreboard on the w_* ports.
module tb_regfile_wport_arbiter;

   localparam int NR = 12;
   localparam int NP = 8;
   localparam int AW = 5;
   localparam int DW = 64;
   localparam int MW = 8;
   localparam int PW = 4;

   logic               clock;
   logic               reset_n;
   logic               hold;
   logic [NR-1:0]      req_valid;
   logic [NR-1:0]      req_ready;
   logic [NR*AW-1:0]   req_addr;
   logic [NR*DW-1:0]   req_data;
   logic [NR*MW-1:0]   req_mask;
   logic [NP-1:0]      w_en;
   logic [NP*AW-1:0]   w_addr;
   logic [NP*DW-1:0]   w_data;
   logic [NP*MW-1:0]   w_mask;
   logic [PW-1:0]      rr_ptr_o;
`ifdef REGFILE_WPORT_ARB_STATS_EN
   logic [31:0]        stat_grants;
   logic [31:0]        stat_conflicts;
`endif

   regfile_wport_arbiter dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .hold      (hold),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_mask  (req_mask),
      .w_en      (w_en),
      .w_addr    (w_addr),
      .w_data    (w_data),
      .w_mask    (w_mask),
`ifdef REGFILE_WPORT_ARB_STATS_EN
      .stat_grants    (stat_grants),
      .stat_conflicts (stat_conflicts),
`endif
      .rr_ptr_o  (rr_ptr_o)
   );

   typedef struct {
      int          cyc;
      int          port;
      logic [4:0]  addr;
      logic [63:0] data;
      logic [7:0]  mask;
   } exp_t;

   exp_t exp_q [$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [63:0] data_of(input int i);
      return {16'hC0DE, 16'(i), 32'hA5A5_0000 + 32'(i)};
   endfunction

   // Requester 3 carries an all-zero mask; it must still be granted.
   function automatic logic [7:0] mask_of(input int i);
      return (i == 3) ? 8'h00 : 8'(i * 17 + 1);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_req(input int i, input int a);
      req_valid[i]          = 1'b1;
      req_addr[i*AW +: AW]  = 5'(a);
      req_data[i*DW +: DW]  = data_of(i);
      req_mask[i*MW +: MW]  = mask_of(i);
   endtask

   task automatic exp_w(input int port, input int i, input int a);
      exp_t e;
      e.cyc  = cyc + 1;
      e.port = port;
      e.addr = 5'(a);
      e.data = data_of(i);
      e.mask = mask_of(i);
      exp_q.push_back(e);
   endtask

   // Monitor: every enabled port must match the next expected write, in order.
   always @(negedge clock) begin
      exp_t e;
      logic bad_dup;
      logic bad_idle;
      if (reset_n) begin
         bad_dup  = 1'b0;
         bad_idle = 1'b0;
         for (int k = 0; k < NP; k++) begin
            if (w_en[k]) begin
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL unexpected_write: port %0d addr %0d at cycle %0d, expected none",
                           k, w_addr[k*AW +: AW], cyc);
               end else begin
                  e = exp_q.pop_front();
                  if (e.cyc != cyc || e.port != k || e.addr !== w_addr[k*AW +: AW] ||
                      e.data !== w_data[k*DW +: DW] || e.mask !== w_mask[k*MW +: MW]) begin
                     n_bad++;
                     $display("FAIL write: got cyc %0d port %0d addr %0d data %0h mask %0h, expected cyc %0d port %0d addr %0d data %0h mask %0h",
                              cyc, k, w_addr[k*AW +: AW], w_data[k*DW +: DW], w_mask[k*MW +: MW],
                              e.cyc, e.port, e.addr, e.data, e.mask);
                  end
               end
               for (int m = k + 1; m < NP; m++)
                  if (w_en[m] && w_addr[m*AW +: AW] == w_addr[k*AW +: AW]) bad_dup = 1'b1;
            end else if (w_addr[k*AW +: AW] != '0 || w_data[k*DW +: DW] != '0 ||
                         w_mask[k*MW +: MW] != '0) begin
               bad_idle = 1'b1;
            end
         end
         if (w_en != '0) begin
            n_cmp++;
            if (bad_dup) begin
               n_bad++;
               $display("FAIL dup_addr: two enabled ports share an address at cycle %0d, expected unique", cyc);
            end
         end
         n_cmp++;
         if (bad_idle) begin
            n_bad++;
            $display("FAIL idle_port_zero: disabled port has nonzero fields at cycle %0d, expected 0", cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n   = 1'b0;
      hold      = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      req_mask  = '0;
      repeat (2) step();

      // Reset state, with requests present to show ready stays low.
      req_valid = '1;
      #1;
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_w_en", 64'(w_en), 64'h0);
      chk("rst_w_data", w_data[63:0], 64'h0);
      chk("rst_ptr", 64'(rr_ptr_o), 64'h0);
      req_valid = '0;
      step();
      reset_n = 1'b1;
      step(); #2;
      chk("idle_ready", 64'(req_ready), 64'h0);
      chk("idle_w_en", 64'(w_en), 64'h0);
      chk("idle_ptr", 64'(rr_ptr_o), 64'h0);
`ifdef REGFILE_WPORT_ARB_STATS_EN
      chk("stat_grants_rst", 64'(stat_grants), 64'h0);
      chk("stat_conf_rst", 64'(stat_conflicts), 64'h0);
`endif

      // All twelve valid, distinct addresses 0..11.
      step();
      for (int i = 0; i < NR; i++) drive_req(i, i);
      #2;
      chk("all_c0_ready", 64'(req_ready), 64'h0FF);
      chk("all_c0_ptr", 64'(rr_ptr_o), 64'h0);
      for (int k = 0; k < 8; k++) exp_w(k, k, k);
      step();
      req_valid[7:0] = '0;
      #2;
      chk("all_c1_ready", 64'(req_ready), 64'hF00);
      chk("all_c1_ptr", 64'(rr_ptr_o), 64'h8);
      for (int k = 0; k < 4; k++) exp_w(k, 8 + k, 8 + k);
      step();
      req_valid = '0;
      #2;
      chk("all_c2_ptr", 64'(rr_ptr_o), 64'h0);
      chk("all_c2_ready", 64'(req_ready), 64'h0);

      // Address conflict: requesters 2 and 5 both target 7.
      step();
      drive_req(2, 7);
      drive_req(5, 7);
      drive_req(9, 3);
      #2;
      chk("conf_c0_ready", 64'(req_ready), 64'h204);
      exp_w(0, 2, 7);
      exp_w(1, 9, 3);
      step();
      req_valid[2] = 1'b0;
      req_valid[9] = 1'b0;
      #2;
      chk("conf_c1_ptr", 64'(rr_ptr_o), 64'd10);
      chk("conf_c1_ready", 64'(req_ready), 64'h020);
      exp_w(0, 5, 7);
      step();
      req_valid[5] = 1'b0;
      #2;
      chk("conf_c2_ptr", 64'(rr_ptr_o), 64'd6);
`ifdef REGFILE_WPORT_ARB_STATS_EN
      chk("stat_grants", 64'(stat_grants), 64'd15);
      chk("stat_conflicts", 64'(stat_conflicts), 64'd1);
`endif

      // Hold for three cycles with everything valid.
      step();
      hold = 1'b1;
      for (int i = 0; i < NR; i++) drive_req(i, 12 + i);
      #2;
      chk("hold_c0_ready", 64'(req_ready), 64'h0);
      for (int h = 1; h < 3; h++) begin
         step(); #2;
         chk("hold_ready", 64'(req_ready), 64'h0);
         chk("hold_w_en", 64'(w_en), 64'h0);
         chk("hold_ptr", 64'(rr_ptr_o), 64'd6);
      end
      step();
      hold = 1'b0;
      #2;
      chk("unhold_w_en", 64'(w_en), 64'h0);
      chk("unhold_ready", 64'(req_ready), 64'hFC3);
      chk("unhold_ptr", 64'(rr_ptr_o), 64'd6);
      for (int k = 0; k < 8; k++) exp_w(k, (6 + k) % NR, 12 + (6 + k) % NR);
      step();
      req_valid[11:6] = '0;
      req_valid[1:0]  = '0;
      #2;
      chk("unhold_c1_ready", 64'(req_ready), 64'h03C);
      chk("unhold_c1_ptr", 64'(rr_ptr_o), 64'd2);
      for (int k = 0; k < 4; k++) exp_w(k, 2 + k, 14 + k);
      step();
      req_valid = '0;
      #2;
      chk("unhold_c2_ptr", 64'(rr_ptr_o), 64'd6);

      // Pointer wrap from 10.
      step();
      drive_req(9, 20);
      #2;
      chk("wrap_pre_ready", 64'(req_ready), 64'h200);
      exp_w(0, 9, 20);
      step();
      req_valid[9] = 1'b0;
      drive_req(10, 30);
      drive_req(11, 31);
      drive_req(0, 0);
      drive_req(1, 1);
      #2;
      chk("wrap_ptr10", 64'(rr_ptr_o), 64'd10);
      chk("wrap_ready", 64'(req_ready), 64'hC03);
      exp_w(0, 10, 30);
      exp_w(1, 11, 31);
      exp_w(2, 0, 0);
      exp_w(3, 1, 1);
      step();
      req_valid = '0;
      #2;
      chk("wrap_ptr2", 64'(rr_ptr_o), 64'd2);

      // Reset pulse in the cycle after a grant: the registered write is dropped.
      step();
      drive_req(4, 9);
      #2;
      chk("rstp_ready", 64'(req_ready), 64'h010);
      step();
      req_valid = '0;
      chk("rstp_pre_w_en", 64'(w_en), 64'h01);
      chk("rstp_pre_addr", 64'(w_addr[4:0]), 64'd9);
      #1;
      reset_n = 1'b0;
      #1;
      chk("rstp_w_en", 64'(w_en), 64'h0);
      chk("rstp_w_addr", 64'(w_addr[4:0]), 64'h0);
      chk("rstp_ptr", 64'(rr_ptr_o), 64'h0);
`ifdef REGFILE_WPORT_ARB_STATS_EN
      chk("rstp_stat_grants", 64'(stat_grants), 64'h0);
      chk("rstp_stat_conf", 64'(stat_conflicts), 64'h0);
`endif
      #1;
      reset_n = 1'b1;
      step(); #2;
      chk("post_rst_w_en", 64'(w_en), 64'h0);
      chk("post_rst_ptr", 64'(rr_ptr_o), 64'h0);

      repeat (2) step();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
